// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipeline_ctrl_pkg;

    // Sequencer state encoding, also exported on the state port.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } hz_state_e;

    // Cycles for MEM and WB to retire before the core reports halted.
    localparam int DRAIN_CYCLES_DEFAULT = 2;

    // Register $zero never creates a dependency.
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decoder-side bundle: ID/EX hazard inputs, resume pulse, stall/flush
// controls and statistics. master = pipeline/decoder, slave = sequencer.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_jmp;
    logic              ex_mem_to_reg;
    logic              ex_reg_write;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_branch_taken;
    logic              ex_jr;
    logic              ex_syscall;
    logic              ex_halt_req;
    logic              go;

    logic              stall_pc;
    logic              stall_if_id;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              halted;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_jmp,
               ex_mem_to_reg, ex_reg_write, ex_dst,
               ex_branch_taken, ex_jr, ex_syscall, ex_halt_req, go,
        input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               halted, state, cyc_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_jmp,
               ex_mem_to_reg, ex_reg_write, ex_dst,
               ex_branch_taken, ex_jr, ex_syscall, ex_halt_req, go,
        output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               halted, state, cyc_cnt, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count on inc until the counter reaches its maximum, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// wrong-path squash on branch/jump, and syscall drain/halt FSM.
// Optional statistics counters are built when HAZARD_STATS_EN is defined;
// otherwise the counter outputs are tied to zero.
//
//   state | meaning
//   RUN   | normal issue; controls decoded combinationally from hazards
//   DRAIN | halting syscall seen; front end frozen while MEM/WB retire
//   HALT  | core stopped; waits for a go pulse
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    hz_state_e      state_q, state_d;
    logic [DCW-1:0] drain_q, drain_d;

    logic load_use, redirect, halt_hit;
    logic stall_pc, stall_if_id, flush_if_id, flush_id_ex;

    assign load_use = bus.ex_mem_to_reg & bus.ex_reg_write
                    & (bus.ex_dst != REG_AW'(REG_ZERO))
                    & ((bus.id_use_rs & (bus.id_rs == bus.ex_dst))
                     | (bus.id_use_rt & (bus.id_rt == bus.ex_dst)));
    assign redirect = bus.ex_branch_taken | bus.ex_jr;
    assign halt_hit = bus.ex_syscall & bus.ex_halt_req;

    // State and drain down-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next state: drain counter reaching zero is the terminal count into HALT.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: begin
                if (halt_hit) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = HALT;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            HALT: begin
                if (bus.go) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Controls: in RUN, halt > redirect > load-use > jump; frozen otherwise.
    always_comb begin
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (state_q == RUN) begin
            if (halt_hit || (!redirect && load_use)) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (redirect) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (bus.id_jmp) begin
                flush_if_id = 1'b1;
            end
        end else begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    assign bus.stall_pc    = stall_pc;
    assign bus.stall_if_id = stall_if_id;
    assign bus.flush_if_id = flush_if_id;
    assign bus.flush_id_ex = flush_id_ex;
    assign bus.halted      = (state_q == HALT);
    assign bus.state       = state_q;

`ifdef HAZARD_STATS_EN
    logic cyc_inc, stall_inc, flush_inc;

    assign cyc_inc   = (state_q != HALT);
    assign stall_inc = (state_q == RUN) & ~halt_hit & ~redirect & load_use;
    assign flush_inc = (state_q == RUN) & ~halt_hit & redirect;

    hazard_sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cyc_inc),
        .cnt   (bus.cyc_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .cnt   (bus.stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .cnt   (bus.flush_cnt)
    );
`else
    assign bus.cyc_cnt   = {CNT_W{1'b0}};
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=4, DRAIN_CYCLES=2).
// Counter expectations collapse to zero when HAZARD_STATS_EN is undefined.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .REG_AW       (REG_AW),
        .CNT_W        (CNT_W),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ce(input int v);
`ifdef HAZARD_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {stall_pc, stall_if_id, flush_if_id, flush_id_ex}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, bus.stall_pc, bus.stall_if_id, bus.flush_if_id, bus.flush_id_ex},
              {28'd0, exp});
    endtask

    task automatic clr();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.id_jmp = 0; bus.ex_mem_to_reg = 0; bus.ex_reg_write = 0; bus.ex_dst = '0;
        bus.ex_branch_taken = 0; bus.ex_jr = 0; bus.ex_syscall = 0;
        bus.ex_halt_req = 0; bus.go = 0;
    endtask

    task automatic load_use_rs();
        bus.ex_mem_to_reg = 1; bus.ex_reg_write = 1; bus.ex_dst = 5'd8;
        bus.id_rs = 5'd8; bus.id_use_rs = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        clr();
        #2;
        check("rst_state", {30'd0, bus.state}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk_ctl("rst_ctl", 4'b0000);
        check("rst_cyc", {28'd0, bus.cyc_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // load-use on rs
        load_use_rs(); #1;
        chk_ctl("lu_rs_ctl", 4'b1101);
        tick();
        check("lu_rs_stall_cnt", {28'd0, bus.stall_cnt}, ce(1));

        // destination is $zero: no hazard
        clr(); load_use_rs(); bus.ex_dst = 5'd0; bus.id_rs = 5'd0; #1;
        chk_ctl("lu_zero_ctl", 4'b0000);
        tick();
        check("lu_zero_stall_cnt", {28'd0, bus.stall_cnt}, ce(1));

        // redirect beats load-use
        clr(); load_use_rs(); bus.ex_branch_taken = 1; #1;
        chk_ctl("br_lu_ctl", 4'b0011);
        tick();
        check("br_lu_flush_cnt", {28'd0, bus.flush_cnt}, ce(1));
        check("br_lu_stall_cnt", {28'd0, bus.stall_cnt}, ce(1));

        // jr alone
        clr(); bus.ex_jr = 1; #1;
        chk_ctl("jr_ctl", 4'b0011);
        tick();
        check("jr_flush_cnt", {28'd0, bus.flush_cnt}, ce(2));

        // load-use on rt
        clr(); bus.ex_mem_to_reg = 1; bus.ex_reg_write = 1; bus.ex_dst = 5'd17;
        bus.id_rt = 5'd17; bus.id_use_rt = 1; bus.id_rs = 5'd17; #1;
        chk_ctl("lu_rt_ctl", 4'b1101);
        tick();

        // jump alone
        clr(); bus.id_jmp = 1; #1;
        chk_ctl("jmp_ctl", 4'b0010);
        tick();

        // jump suppressed under load-use
        clr(); load_use_rs(); bus.id_jmp = 1; #1;
        chk_ctl("jmp_lu_ctl", 4'b1101);
        tick();
        check("jmp_lu_stall_cnt", {28'd0, bus.stall_cnt}, ce(3));
        check("jmp_lu_flush_cnt", {28'd0, bus.flush_cnt}, ce(2));

        // non-load producer, and matching rs that is not read
        clr(); load_use_rs(); bus.ex_mem_to_reg = 0; #1;
        chk_ctl("no_load_ctl", 4'b0000);
        clr(); load_use_rs(); bus.id_use_rs = 0; #1;
        chk_ctl("no_use_ctl", 4'b0000);
        tick();
        check("no_use_stall_cnt", {28'd0, bus.stall_cnt}, ce(3));

        // halt has priority over a simultaneous branch (cycle T)
        clr(); bus.ex_syscall = 1; bus.ex_halt_req = 1; bus.ex_branch_taken = 1; #1;
        chk_ctl("halt_ctl", 4'b1101);
        tick();
        check("halt_flush_cnt", {28'd0, bus.flush_cnt}, ce(2));
        // T+1: DRAIN, go and redirect ignored
        clr(); bus.go = 1; bus.ex_branch_taken = 1; #1;
        check("drain1_state", {30'd0, bus.state}, 32'd1);
        check("drain1_halted", {31'd0, bus.halted}, 32'd0);
        chk_ctl("drain1_ctl", 4'b1101);
        tick();
        // T+2: still DRAIN
        check("drain2_state", {30'd0, bus.state}, 32'd1);
        tick();
        // T+3: HALT
        clr(); #1;
        check("halt_state", {30'd0, bus.state}, 32'd2);
        check("halt_halted", {31'd0, bus.halted}, 32'd1);
        chk_ctl("halt_hold_ctl", 4'b1101);
        tick();
        check("halt_hold_state", {30'd0, bus.state}, 32'd2);
        bus.go = 1;
        tick();
        bus.go = 0; #1;
        check("resume_state", {30'd0, bus.state}, 32'd0);
        check("resume_halted", {31'd0, bus.halted}, 32'd0);
        chk_ctl("resume_ctl", 4'b0000);
        bus.id_jmp = 1; #1;
        chk_ctl("resume_jmp_ctl", 4'b0010);
        tick();

        // reset in the middle of DRAIN
        clr(); bus.ex_syscall = 1; bus.ex_halt_req = 1;
        tick();
        clr();
        check("pre_rst_state", {30'd0, bus.state}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_state", {30'd0, bus.state}, 32'd0);
        check("mid_rst_halted", {31'd0, bus.halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; #1;
        check("post_rst_cyc", {28'd0, bus.cyc_cnt}, 32'd0);
        check("post_rst_stall", {28'd0, bus.stall_cnt}, 32'd0);
        check("post_rst_flush", {28'd0, bus.flush_cnt}, 32'd0);
        check("post_rst_state", {30'd0, bus.state}, 32'd0);

        // cyc_cnt counts RUN/DRAIN only, then saturates
        bus.ex_syscall = 1; bus.ex_halt_req = 1;
        tick();
        clr();
        tick();
        tick();
        check("cyc_at_halt_state", {30'd0, bus.state}, 32'd2);
        check("cyc_at_halt", {28'd0, bus.cyc_cnt}, ce(3));
        tick();
        tick();
        check("cyc_in_halt", {28'd0, bus.cyc_cnt}, ce(3));
        bus.go = 1;
        tick();
        bus.go = 0;
        check("cyc_resume", {28'd0, bus.cyc_cnt}, ce(3));
        repeat (11) tick();
        check("cyc_14", {28'd0, bus.cyc_cnt}, ce(14));
        repeat (9) tick();
        check("cyc_sat", {28'd0, bus.cyc_cnt}, ce(15));
        check("stall_after_rst", {28'd0, bus.stall_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencer for the 5-stage MIPS pipeline. It sits beside the instruction decoder and produces stall and flush controls for the PC, IF/ID and ID/EX registers. It detects load-use hazards, squashes wrong-path fetches on taken branches and jumps, and runs a drain/halt state machine for the halting `syscall`. Optionally it keeps saturating performance counters.

## Interface
- `REG_AW`, 5: register-number width.
- `CNT_W`, 32: statistics counter width.
- `DRAIN_CYCLES`, 2: cycles needed for the MEM and WB stages to retire before halt.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `id_rs`, `id_rt`  in  REG_AW each  source registers of the instruction in ID.
- `id_use_rs`, `id_use_rt`  in  1 each  the ID instruction actually reads rs / rt.
- `id_jmp`  in  1  `j` or `jal` decoded in ID.
- `ex_mem_to_reg`, `ex_reg_write`  in  1 each  decoder flags of the instruction in EX.
- `ex_dst`  in  REG_AW  destination register of the instruction in EX.
- `ex_branch_taken`  in  1  `beq`/`bne`/`blez` resolved taken in EX.
- `ex_jr`  in  1  `jr` in EX.
- `ex_syscall`  in  1  `syscall` in EX.
- `ex_halt_req`  in  1  `$v0 == 10` at that `syscall`.
- `go`  in  1  one-cycle resume pulse.
- `stall_pc`, `stall_if_id`  out  1 each  hold PC / hold IF/ID.
- `flush_if_id`, `flush_id_ex`  out  1 each  load a bubble.
- `halted`  out  1  core stopped.
- `state`  out  2  RUN=0, DRAIN=1, HALT=2.
- `cyc_cnt`, `stall_cnt`, `flush_cnt`  out  CNT_W each  statistics.

## Operation
- `load_use` = `ex_mem_to_reg & ex_reg_write & (ex_dst != 0) & ((id_use_rs & id_rs == ex_dst) | (id_use_rt & id_rt == ex_dst))`.
- `redirect` = `ex_branch_taken | ex_jr`.
- `halt_hit` = `ex_syscall & ex_halt_req`.

**RUN state.** Outputs are combinational. Priority, highest first:
- `halt_hit`
  - Asserts `stall_pc`, `stall_if_id` and `flush_id_ex`.
  - Next state is DRAIN; the drain counter loads DRAIN_CYCLES-1.
- `redirect`
  - Asserts `flush_if_id` and `flush_id_ex`.
  - Overrides `load_use`, because the ID instruction is on the wrong path.
- `load_use`
  - Asserts `stall_pc`, `stall_if_id` and `flush_id_ex`.
  - `id_jmp` is suppressed this cycle; the jump re-decodes next cycle.
- `id_jmp`
  - Asserts `flush_if_id` only.
- Otherwise all four controls are 0.

**DRAIN state.**
- `stall_pc`, `stall_if_id` and `flush_id_ex` are held at 1.
- The drain counter decrements each cycle; at 0 the next state is HALT.
- `redirect`, `load_use`, `id_jmp` and `go` are ignored.

**HALT state.**
- `stall_pc`, `stall_if_id` and `flush_id_ex` are 1; `halted` = 1.
- `go` = 1 moves to RUN on the next edge. In the RUN cycle after resume, all controls are again computed from the inputs.

**General rules.**
- `go` is ignored outside HALT.
- Reset mid-DRAIN or mid-HALT returns to RUN immediately, asynchronously.

## Timing
- Stall and flush outputs have zero-cycle latency from their inputs in RUN. `halted` and `state` come directly from registers.
- Halt latency: the `halt_hit` cycle T is in RUN, cycles T+1..T+DRAIN_CYCLES are DRAIN, and `halted` rises at T+DRAIN_CYCLES+1.
- Resume: `go` sampled at cycle H gives `state` = RUN at H+1.
- Reset values: `state` = RUN, `halted` = 0, drain counter 0, all counters 0. With all inputs 0, the stall and flush outputs are 0.
- Statistics counters (RUN/DRAIN only):
  - `cyc_cnt` +1 every non-HALT cycle.
  - `stall_cnt` +1 on each cycle `load_use` wins.
  - `flush_cnt` +1 on each cycle `redirect` wins.
- All counters saturate at 2^CNT_W-1 and never wrap.

## Configuration
- `HAZARD_STATS_EN` defined: the three counters are implemented as above.
- `HAZARD_STATS_EN` undefined: no counter flops; `cyc_cnt`, `stall_cnt` and `flush_cnt` are tied to 0. The ports remain, so the interface is identical.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - 2-bit state enum RUN/DRAIN/HALT.
  - `DRAIN_CYCLES` default.
  - `REG_ZERO` constant.
- One sub-module, `hazard_sat_counter`: a CNT_W saturating counter with `clk`, `rst_n` and `inc` inputs. It is instantiated three times under `HAZARD_STATS_EN`.

## Test plan
- Load-use stall:
  - Stimulus: `ex_mem_to_reg=1`, `ex_reg_write=1`, `ex_dst=8`, `id_rs=8`, `id_use_rs=1`.
  - Response: `stall_pc=stall_if_id=flush_id_ex=1`, `flush_if_id=0`, `stall_cnt` +1.
  - Same stimulus with `ex_dst=0`: all four controls 0.
- Redirect beats load-use: load-use stimulus plus `ex_branch_taken=1` -> `flush_if_id=flush_id_ex=1`, `stall_pc=0`, `flush_cnt` +1, `stall_cnt` unchanged.
- Jump under stall: `id_jmp=1` alone -> only `flush_if_id=1`. `id_jmp=1` with load-use -> `flush_if_id=0`, stall asserted.
- Halt sequence:
  - Stimulus: `ex_syscall=ex_halt_req=1` at cycle 10.
  - Response: `state`=DRAIN at cycles 11-12, HALT and `halted=1` at cycle 13.
  - `go` at cycle 12 is ignored; `go` at cycle 15 gives `state`=RUN at cycle 16.
- Reset mid-DRAIN: drop `rst_n` at cycle 11 -> `state`=RUN and `halted=0` immediately; counters read 0 after release.
- Saturation (CNT_W=4, `HAZARD_STATS_EN`): 20 RUN cycles -> `cyc_cnt=15` and it holds. Without the macro, all counters read 0.
